// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_reader_pkg : shared state encoding and buffer sizing for fifo_reader  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package fifo_reader_pkg;

  localparam int BUF_DEPTH = 2;
  // Occupancy counter width: must hold 0..BUF_DEPTH plus one in-flight read.
  localparam int CNT_W     = $clog2(BUF_DEPTH + 2);
  localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_reader_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_reader_skid : 2-entry circular output buffer with occupancy count     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= (r_wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      // Simultaneous write and read leave occupancy unchanged.
      r_count <= r_count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_reader : reads a burst of len words from a synchronous FIFO and       |
// | streams them out over valid/ready. FIFO_READER_STATS_EN adds word_count.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [31:0]           word_count
`endif
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic [LEN_WIDTH-1:0]  r_accepted;
  logic                  r_inflight;
  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_occ;
  logic                  w_pop;
  logic                  w_room;
  logic                  w_rd;
  logic                  w_last_issue;
  logic                  w_last_accept;
  logic                  w_launch;

  assign w_pop = m_valid & m_ready;

  // A word leaving this cycle frees its slot in time for a read issued now,
  // which is what sustains one word per cycle.
  assign w_occ  = w_count - CNT_W'(w_pop);
  assign w_room = (w_occ + CNT_W'(r_inflight)) < CNT_W'(BUF_DEPTH);

  assign w_rd          = (r_state == FETCH) && !fifo_empty && (r_issued < r_len) && w_room;
  assign w_last_issue  = w_rd && (r_issued == r_len - LEN_WIDTH'(1));
  assign w_last_accept = w_pop && (r_accepted == r_len - LEN_WIDTH'(1)) && !r_inflight;
  assign w_launch      = (r_state == IDLE) && start && (len != '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (w_last_issue) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (w_last_accept) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd;
      if (w_launch) begin
        r_len      <= len;
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (w_rd) begin
          r_issued <= r_issued + LEN_WIDTH'(1);
        end
        if (w_pop && (r_accepted != r_len)) begin
          r_accepted <= r_accepted + LEN_WIDTH'(1);
        end
      end
    end
  end

  fifo_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (r_inflight),
    .wr_data (fifo_rdata),
    .rd_en   (w_pop),
    .rd_data (m_data),
    .count   (w_count)
  );

  assign m_valid   = (w_count != '0);
  assign fifo_r_en = w_rd;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

`ifdef FIFO_READER_STATS_EN
  logic [31:0] r_word_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_count <= '0;
    end else if (w_pop) begin
      r_word_count <= r_word_count + 32'd1;
    end
  end

  assign word_count = r_word_count;
`endif

endmodule
`default_nettype wire
